zone_mean_fifo: RTL and testbench
=================================

Name: zone_mean_fifo

Overview:
- Parametrised single-clock successor to the per-row zone-mean port buffer in the local-dimming path.
- Captures the first ZONES samples of every STRIDE-long valid burst of zone means from the mean stage.
- Buffers them in an internal synchronous FIFO.
- Replays one row of ZONES entries per rd_start over a valid/ready handshake, tagged with zone index and last-of-row, to the LED driver side.

Parameters:
DW, 24, zone mean data width (bits)
ZONES, 40, zones captured per row; 1 <= ZONES <= STRIDE
STRIDE, 42, samples per valid burst period; capture counter wraps at STRIDE
DEPTH, 64, FIFO entries; power of 2, >= ZONES
AW, $clog2(DEPTH), pointer width (derived, not overridden)
ZW, $clog2(STRIDE), zone counter width (derived)

Ports:
clk  in  1  sole clock
rst_n  in  1  synchronous active-low reset
clear  in  1  sync flush: empties FIFO, FSM to IDLE, capture counter to 0
din_valid  in  1  input sample qualifier
din  in  DW  zone mean sample
rd_start  in  1  pulse: request replay of one row
dout_valid  out  1  dout holds a valid entry
dout_ready  in  1  consumer accepts dout
dout  out  DW  FIFO head (first-word fall-through)
dout_zone  out  ZW  zone index 0..ZONES-1 of dout within current replay row
dout_last  out  1  dout is zone ZONES-1
busy  out  1  replay row in progress
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  AW+1  entries held

Behaviour:
- Reset (rst_n low at clk edge):
  - Pointers and level 0, so empty=1 and full=0.
  - FSM IDLE, so busy=0, dout_valid=0, dout_zone=0, dout_last=0.
  - dout undefined-but-stable; the bench ignores it while dout_valid=0.
- Capture counter cap_cnt:
  - din_valid=0 -> cap_cnt=0.
  - din_valid=1 -> cap_cnt increments, wrapping STRIDE-1 -> 0.
- Push:
  - Push occurs when din_valid=1 and cap_cnt < ZONES.
  - din is written in the same cycle it arrives; zero-latency capture, no data/enable skew.
  - Samples at cap_cnt >= ZONES are discarded.
- Pop = dout_valid & dout_ready.
- Push on full:
  - Accepted only if a pop happens in the same cycle; otherwise the sample is dropped and pointers are unchanged.
- Simultaneous push+pop: level unchanged, both pointers advance.
- Push on empty: the entry is visible on dout the next cycle (1-cycle write-to-read latency).
- Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: rd_start=1 -> BURST, rd_zone=0.
  - BURST:
    - dout_valid = !empty.
    - On pop: if rd_zone == ZONES-1 -> IDLE, else rd_zone+1.
    - rd_start during BURST is ignored; it is not queued.
    - Empty mid-row: dout_valid drops and the FSM waits in BURST; data may be drained across gaps.
- Outputs: busy = (state==BURST); dout_zone = rd_zone; dout_last = BURST & (rd_zone==ZONES-1).
- clear:
  - Has priority over push/pop in the same cycle.
  - Resets pointers, level, FSM and rd_zone; cap_cnt is also zeroed.
- Reset mid-burst or mid-capture: all state returns to reset values; no partial row is replayed.

Optional Feature:
- Macro ZONE_MEAN_FIFO_STATS_EN.
- When defined, add outputs:
  - overflow (1): sticky, set on any dropped push, cleared by reset/clear.
  - drop_cnt (16): saturating count of dropped pushes.
  - underrun (1): sticky, set when BURST and empty for any cycle.
- When undefined, these ports and their logic are absent; core behaviour is identical.

Decomposition:
- Shared package zone_mean_pkg holds:
  - FSM state typedef (IDLE, BURST);
  - default DW/ZONES/STRIDE/DEPTH localparams;
  - DROP_CNT_W=16.
- One natural sub-module: sync_fifo_fwft (param DW, DEPTH), containing the storage, pointers, level, full/empty and FWFT read.
- The top holds the capture counter, replay FSM and stats.

Test Plan:
- Capture: din_valid high for 42 cycles, din=i for i=0..41 -> level=40 afterwards, entries 0..39 stored, 40/41 discarded.
- Replay: after capture, pulse rd_start, dout_ready=1 -> dout 0..39 on 40 consecutive cycles, dout_zone=0..39, dout_last only on 39, then busy=0 and empty=1.
- Backpressure: toggle dout_ready 1/0 during replay -> no duplicated or lost entries, dout stable while dout_valid=1 & dout_ready=0.
- Boundaries: DEPTH=64, two rows captured (80 pushes) -> level=64, full=1, 16 drops. With STATS_EN: overflow=1, drop_cnt=16. A push with a simultaneous pop at full is accepted.
- Empty gap: rd_start with only 10 entries -> 10 pops, then dout_valid=0 and busy=1. Capture a further 40 -> replay resumes at zone 10 and ends at zone 39.
- Reset/clear mid-burst: rst_n=0 (or clear=1) at zone 20 -> next cycle busy=0, level=0, dout_valid=0. rd_start during BURST does not add a second row.

Source files
------------

// File: rtl/zone_mean_pkg.sv
// ---------------------------------------------------------------------------
// zone_mean_pkg
// Shared definitions for the zone-mean row buffer: default geometry, the
// width of the optional drop counter and the replay FSM state type.
// ---------------------------------------------------------------------------
package zone_mean_pkg;

  localparam int DEF_DW     = 24;  // zone mean width
  localparam int DEF_ZONES  = 40;  // zones kept per row
  localparam int DEF_STRIDE = 42;  // samples per burst period
  localparam int DEF_DEPTH  = 64;  // FIFO entries (power of 2)

  localparam int DROP_CNT_W = 16;  // saturating dropped-push counter width

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage : zone_mean_pkg

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// dout combinationally from the storage array, so a word written into an
// empty FIFO is readable the cycle after the write.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clear       synchronous flush, wins over write/read in the same cycle
//   wr_req      write request; taken when not full, or when full and a read
//               happens in the same cycle
//   din         write data
//   rd_req      read (pop) request; ignored while empty
//   dout        head entry (undefined while empty)
//   full/empty  level == DEPTH / level == 0
//   level       number of entries held
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter  int DW    = 24,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_req,
  input  logic [DW-1:0] din,
  input  logic          rd_req,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          wr_en, rd_en;

  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A write into a full FIFO is only safe when the head leaves in the same
  // cycle, freeing the slot the write pointer is about to overwrite.
  assign rd_en = rd_req & ~empty;
  assign wr_en = wr_req & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of 2.
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // visible once level covers it, so its power-up contents never escape.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule : sync_fifo_fwft

// File: rtl/zone_mean_fifo.sv
// ---------------------------------------------------------------------------
// zone_mean_fifo
// Per-row zone-mean buffer for the local-dimming path. Keeps the first ZONES
// samples of every STRIDE-long valid burst, buffers them in a FWFT FIFO and
// replays one row of ZONES entries per rd_start over valid/ready, tagged
// with the zone index and a last-of-row flag.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        synchronous flush: FIFO empty, FSM IDLE, capture count 0
//   din_valid    sample qualifier; low restarts the capture count
//   din          zone mean sample
//   rd_start     pulse requesting replay of one row (ignored while busy)
//   dout_valid   dout holds a valid entry of the current row
//   dout_ready   consumer accepts dout
//   dout         FIFO head
//   dout_zone    zone index of dout within the replay row
//   dout_last    dout is the final zone of the row
//   busy         replay row in progress
//   full, empty, level   FIFO status
//
// Optional build macro ZONE_MEAN_FIFO_STATS_EN adds:
//   overflow     sticky, set on any dropped push
//   drop_cnt     saturating count of dropped pushes
//   underrun     sticky, set on any cycle spent in a row with the FIFO empty
// ---------------------------------------------------------------------------
module zone_mean_fifo
  import zone_mean_pkg::*;
#(
  parameter  int DW     = DEF_DW,
  parameter  int ZONES  = DEF_ZONES,
  parameter  int STRIDE = DEF_STRIDE,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int ZW     = (STRIDE > 1) ? $clog2(STRIDE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          rd_start,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout,
  output logic [ZW-1:0] dout_zone,
  output logic          dout_last,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
`ifdef ZONE_MEAN_FIFO_STATS_EN
  ,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  underrun
`endif
);

  localparam logic [ZW-1:0] ZONE_LAST   = ZW'(ZONES - 1);
  localparam logic [ZW-1:0] STRIDE_LAST = ZW'(STRIDE - 1);

  state_e        state_q,   state_d;
  logic [ZW-1:0] rd_zone_q, rd_zone_d;
  logic [ZW-1:0] cap_cnt_q, cap_cnt_d;
  logic          push_req;
  logic          pop;

  // ---------------- capture ----------------
  // The push decision uses the count *before* this sample is counted, so the
  // sample arriving with cap_cnt == k is burst position k.
  assign push_req = din_valid & (cap_cnt_q <= ZONE_LAST);

  always_comb begin
    cap_cnt_d = cap_cnt_q;
    if (clear || !din_valid)          cap_cnt_d = '0;
    else if (cap_cnt_q == STRIDE_LAST) cap_cnt_d = '0;
    else                               cap_cnt_d = cap_cnt_q + 1'b1;
  end

  // ---------------- storage ----------------
  sync_fifo_fwft #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .wr_req (push_req),
    .din    (din),
    .rd_req (pop),
    .dout   (dout),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // ---------------- replay FSM ----------------
  assign busy       = (state_q == BURST);
  assign dout_valid = busy & ~empty;
  assign pop        = dout_valid & dout_ready;
  assign dout_zone  = rd_zone_q;
  assign dout_last  = busy & (rd_zone_q == ZONE_LAST);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_zone_d = rd_zone_q;
    if (clear) begin
      state_d   = IDLE;
      rd_zone_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_start) begin
            state_d   = BURST;
            rd_zone_d = '0;
          end
        end
        BURST: begin
          // rd_start is not looked at here: a request during a row is lost.
          if (pop) begin
            if (rd_zone_q == ZONE_LAST) begin
              state_d   = IDLE;
              rd_zone_d = '0;
            end else begin
              rd_zone_d = rd_zone_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          rd_zone_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_zone_q <= '0;
      cap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_zone_q <= rd_zone_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

`ifdef ZONE_MEAN_FIFO_STATS_EN
  // ---------------- statistics ----------------
  logic                  drop;
  logic                  overflow_q, overflow_d;
  logic                  underrun_q, underrun_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Mirrors the FIFO write qualifier: a full FIFO only takes a sample when
  // the head is popped in the same cycle.
  assign drop = push_req & full & ~pop;

  always_comb begin
    overflow_d = overflow_q;
    underrun_d = underrun_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      overflow_d = 1'b0;
      underrun_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
      if (busy && empty) underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign underrun = underrun_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule : zone_mean_fifo

// File: tb/tb_zone_mean_fifo.sv
// ---------------------------------------------------------------------------
// tb_zone_mean_fifo
// Directed bench for zone_mean_fifo at its default geometry (DW=24,
// ZONES=40, STRIDE=42, DEPTH=64). Stimulus pushes the hand-derived replay
// entries into a scoreboard queue; a negedge monitor compares every
// presented entry against the queue head and pops it when accepted.
// ---------------------------------------------------------------------------
module tb_zone_mean_fifo;

  localparam int DW = 24;
  localparam int ZW = 6;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          rd_start;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic [ZW-1:0] dout_zone;
  logic          dout_last;
  logic          busy;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
`ifdef ZONE_MEAN_FIFO_STATS_EN
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic          underrun;
`endif

  always #5 clk = ~clk;

  zone_mean_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .din_valid  (din_valid),
    .din        (din),
    .rd_start   (rd_start),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_zone  (dout_zone),
    .dout_last  (dout_last),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .level      (level)
`ifdef ZONE_MEAN_FIFO_STATS_EN
    ,
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .underrun   (underrun)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [ZW-1:0] z;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // din_valid high for n cycles carrying base, base+1, ...
  task automatic burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din       = DW'(base + i);
      tick();
    end
    din_valid = 1'b0;
    din       = '0;
  endtask

  // Expected replay entries for zones z0..z1, data starting at base.
  task automatic push_exp(input int base, input int z0, input int z1);
    exp_t e;
    for (int z = z0; z <= z1; z++) begin
      e.d = DW'(base + z - z0);
      e.z = ZW'(z);
      e.l = (z == 39);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_rd_start();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  // Wait until the scoreboard has consumed every expected entry.
  task automatic wait_drain(input int max_cyc, input bit toggle, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < max_cyc) begin
      if (toggle) dout_ready = ~dout_ready;
      tick();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries still expected after %0d cycles", exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  // Monitor: compare every presented entry with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clear === 1'b0 && dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_dout: actual data=%0d zone=%0d, required no entry", dout, dout_zone);
      end else begin
        check("dout_entry", {1'b0, dout, dout_zone, dout_last}, {1'b0, exp_q[0]});
        if (dout_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n      = 1'b0;
    clear      = 1'b0;
    din_valid  = 1'b0;
    din        = '0;
    rd_start   = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // ---- reset state ----
    check("rst_level",      32'(level),      32'd0);
    check("rst_empty",      32'(empty),      32'd1);
    check("rst_full",       32'(full),       32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_zone",  32'(dout_zone),  32'd0);
    check("rst_dout_last",  32'(dout_last),  32'd0);

    // ---- capture: 42 samples, first 40 kept ----
    burst(0, 42);
    check("cap_level", 32'(level), 32'd40);

    // ---- replay at full rate: 40 pops on 40 consecutive cycles ----
    push_exp(0, 0, 39);
    dout_ready = 1'b1;
    pulse_rd_start();
    wait_drain(100, 1'b0, cyc);
    check("replay_cycles", 32'(cyc),   32'd40);
    check("replay_busy",   32'(busy),  32'd0);
    check("replay_empty",  32'(empty), 32'd1);

    // ---- backpressure: ready toggles every cycle ----
    burst(100, 42);
    push_exp(100, 0, 39);
    pulse_rd_start();
    wait_drain(200, 1'b1, cyc);
    dout_ready = 1'b1;
    check("bp_busy",  32'(busy),  32'd0);
    check("bp_empty", 32'(empty), 32'd1);

    // ---- overflow: two rows (80 pushes) into 64 entries ----
    dout_ready = 1'b0;
    burst(200, 84);
    check("ovf_level", 32'(level), 32'd64);
    check("ovf_full",  32'(full),  32'd1);
`ifdef ZONE_MEAN_FIFO_STATS_EN
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd16);
    check("ovf_underrun", 32'(underrun), 32'd0);
`endif

    // push with a simultaneous pop while full is accepted
    push_exp(200, 0, 39);
    dout_ready = 1'b1;
    pulse_rd_start();
    din_valid = 1'b1;
    din       = DW'(999);
    tick();
    din_valid = 1'b0;
    check("pushpop_level", 32'(level), 32'd64);
    check("pushpop_full",  32'(full),  32'd1);
`ifdef ZONE_MEAN_FIFO_STATS_EN
    check("pushpop_drop_cnt", 32'(drop_cnt), 32'd16);
`endif
    wait_drain(100, 1'b0, cyc);
    // 242..265 plus the accepted 999 remain
    check("pushpop_after_level", 32'(level), 32'd25);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
`ifdef ZONE_MEAN_FIFO_STATS_EN
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // ---- empty gap: row starts with only 10 entries ----
    burst(500, 10);
    check("gap_level", 32'(level), 32'd10);
    push_exp(500, 0, 9);
    pulse_rd_start();
    wait_drain(50, 1'b0, cyc);
    tick();
    check("gap_dout_valid", 32'(dout_valid), 32'd0);
    check("gap_busy",       32'(busy),       32'd1);
    check("gap_zone",       32'(dout_zone),  32'd10);
    // a request during the row must not queue a second row
    pulse_rd_start();
    push_exp(600, 10, 39);
    burst(600, 42);
    wait_drain(100, 1'b0, cyc);
    tick();
    check("gap_end_busy",  32'(busy),  32'd0);
    check("gap_end_level", 32'(level), 32'd10);
`ifdef ZONE_MEAN_FIFO_STATS_EN
    check("gap_underrun", 32'(underrun), 32'd1);
`endif

    // ---- clear at zone 20 ----
    dout_ready = 1'b0;
    burst(700, 42);
    check("mid_level", 32'(level), 32'd50);
    push_exp(630, 0, 9);
    push_exp(700, 10, 19);
    dout_ready = 1'b1;
    pulse_rd_start();
    wait_drain(100, 1'b0, cyc);
    dout_ready = 1'b0;
    check("mid_zone",  32'(dout_zone),  32'd20);
    check("mid_valid", 32'(dout_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("midclr_busy",  32'(busy),       32'd0);
    check("midclr_level", 32'(level),      32'd0);
    check("midclr_valid", 32'(dout_valid), 32'd0);
    check("midclr_zone",  32'(dout_zone),  32'd0);

    // ---- reset at zone 20 ----
    burst(800, 30);
    push_exp(800, 0, 19);
    dout_ready = 1'b1;
    pulse_rd_start();
    wait_drain(100, 1'b0, cyc);
    dout_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_level", 32'(level),      32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_last",  32'(dout_last),  32'd0);

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_zone_mean_fifo
